// File: rtl/jam_gen_pkg.sv
// Shared types and helpers for the jam_gen job-assignment engine.
package jam_gen_pkg;

    typedef enum logic [1:0] {
        LOAD,
        ENUM,
        DONE
    } state_t;

    // Address width for N workers/jobs, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = $clog2(n);
        if (r < 1) r = 1;
        return r;
    endfunction

    function automatic longint unsigned factorial(input int unsigned n);
        longint unsigned f;
        f = 1;
        for (int unsigned i = 2; i <= n; i++) f = f * longint'(i);
        return f;
    endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of a permutation; is_last flags the
// strictly descending (final) permutation.
module jam_next_perm
    import jam_gen_pkg::*;
#(
    parameter  int unsigned N  = 8,
    localparam int unsigned IW = clog2_min1(N)
) (
    input  logic [IW-1:0] perm      [N],
    output logic [IW-1:0] next_perm [N],
    output logic          is_last
);

    logic [IW-1:0] piv;
    logic [IW-1:0] succ;
    logic          found;
    logic [IW-1:0] swp [N];

    always_comb begin
        piv   = '0;
        found = 1'b0;
        for (int k = 0; k < N - 1; k++) begin
            if (perm[k] < perm[k+1]) begin
                piv   = IW'(k);
                found = 1'b1;
            end
        end
        succ = piv;
        for (int k = 0; k < N; k++) begin
            if ((IW'(k) > piv) && (perm[k] > perm[piv])) succ = IW'(k);
        end
        swp       = perm;
        swp[piv]  = perm[succ];
        swp[succ] = perm[piv];
        next_perm = swp;
        // Suffix after the pivot is descending; reversing it makes it ascending.
        for (int k = 0; k < N; k++) begin
            if (IW'(k) > piv) next_perm[k] = swp[IW'(int'(N) + int'(piv) - k)];
        end
        is_last = ~found;
    end

endmodule

// File: rtl/jam_gen.sv
// Exhaustive N x N job-assignment engine: loads a cost matrix, scores every
// permutation, reports min cost and tie count. Optional JAM_BEST_PERM_EN adds BestPerm.
module jam_gen
    import jam_gen_pkg::*;
#(
    parameter  int unsigned N     = 8,
    parameter  int unsigned CW    = 7,
    parameter  int unsigned SUM_W = 10,
    parameter  int unsigned MC_W  = 16,
    localparam int unsigned IW    = clog2_min1(N)
) (
    input  logic             CLK,
    input  logic             RST,
    output logic [IW-1:0]    W,
    output logic [IW-1:0]    J,
    input  logic [CW-1:0]    Cost,
    output logic [MC_W-1:0]  MatchCount,
    output logic [SUM_W-1:0] MinCost,
    output logic             Valid
`ifdef JAM_BEST_PERM_EN
    ,
    output logic [N*IW-1:0]  BestPerm
`endif
);

    localparam int unsigned NN = N * N;
    localparam int unsigned KW = $clog2(NN + 1);

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [IW-1:0]    w_q, w_d, j_q, j_d;
    logic [IW-1:0]    cw_q, cw_d, cj_q, cj_d;
    logic [CW-1:0]    mat_q [N][N];
    logic [CW-1:0]    mat_d [N][N];
    logic [IW-1:0]    perm_q [N];
    logic [IW-1:0]    perm_d [N];
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             sum_vld_q, sum_vld_d;
    logic             sum_last_q, sum_last_d;
    logic             cmp_last_q, cmp_last_d;
    logic             first_q, first_d;
    logic [SUM_W-1:0] min_q, min_d;
    logic [MC_W-1:0]  cnt_q, cnt_d;
    logic             valid_q, valid_d;
`ifdef JAM_BEST_PERM_EN
    logic [IW-1:0]    sum_perm_q [N];
    logic [IW-1:0]    sum_perm_d [N];
    logic [IW-1:0]    best_q [N];
    logic [IW-1:0]    best_d [N];
`endif

    logic [SUM_W-1:0] sum_c;
    logic [IW-1:0]    next_perm_c [N];
    logic             is_last_c;

    jam_next_perm #(.N(N)) u_next_perm (
        .perm      (perm_q),
        .next_perm (next_perm_c),
        .is_last   (is_last_c)
    );

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < N; i++) sum_c = sum_c + SUM_W'(mat_q[i][perm_q[i]]);
    end

    // Next-state: load sequencer, permutation walker and compare stage.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        w_d        = w_q;
        j_d        = j_q;
        cw_d       = cw_q;
        cj_d       = cj_q;
        mat_d      = mat_q;
        perm_d     = perm_q;
        sum_d      = sum_q;
        sum_vld_d  = 1'b0;
        sum_last_d = 1'b0;
        cmp_last_d = 1'b0;
        first_d    = first_q;
        min_d      = min_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q | cmp_last_q;
`ifdef JAM_BEST_PERM_EN
        sum_perm_d = sum_perm_q;
        best_d     = best_q;
`endif

        case (state_q)
            LOAD: begin
                // Cost arrives one cycle after its address, so capture the previous one.
                if (k_q != '0) mat_d[cw_q][cj_q] = Cost;
                cw_d = w_q;
                cj_d = j_q;
                if (k_q == KW'(NN)) begin
                    state_d = ENUM;
                end else begin
                    k_d = k_q + KW'(1);
                    if (k_q == KW'(NN - 1)) begin
                        w_d = '0;
                        j_d = '0;
                    end else if (j_q == IW'(N - 1)) begin
                        j_d = '0;
                        w_d = w_q + IW'(1);
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end
            end
            ENUM: begin
                sum_d      = sum_c;
                sum_vld_d  = 1'b1;
                sum_last_d = is_last_c;
`ifdef JAM_BEST_PERM_EN
                sum_perm_d = perm_q;
`endif
                if (is_last_c) state_d = DONE;
                else           perm_d  = next_perm_c;
            end
            DONE: begin
            end
            default: state_d = LOAD;
        endcase

        if (sum_vld_q) begin
            cmp_last_d = sum_last_q;
            if (first_q || (sum_q < min_q)) begin
                first_d = 1'b0;
                min_d   = sum_q;
                cnt_d   = MC_W'(1);
`ifdef JAM_BEST_PERM_EN
                best_d  = sum_perm_q;
`endif
            end else if (sum_q == min_q) begin
                if (cnt_q != '1) cnt_d = cnt_q + MC_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= LOAD;
            k_q        <= '0;
            w_q        <= '0;
            j_q        <= '0;
            cw_q       <= '0;
            cj_q       <= '0;
            mat_q      <= '{default: '0};
            for (int i = 0; i < N; i++) perm_q[i] <= IW'(i);
            sum_q      <= '0;
            sum_vld_q  <= 1'b0;
            sum_last_q <= 1'b0;
            cmp_last_q <= 1'b0;
            first_q    <= 1'b1;
            min_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
`ifdef JAM_BEST_PERM_EN
            sum_perm_q <= '{default: '0};
            best_q     <= '{default: '0};
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            w_q        <= w_d;
            j_q        <= j_d;
            cw_q       <= cw_d;
            cj_q       <= cj_d;
            mat_q      <= mat_d;
            perm_q     <= perm_d;
            sum_q      <= sum_d;
            sum_vld_q  <= sum_vld_d;
            sum_last_q <= sum_last_d;
            cmp_last_q <= cmp_last_d;
            first_q    <= first_d;
            min_q      <= min_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
`ifdef JAM_BEST_PERM_EN
            sum_perm_q <= sum_perm_d;
            best_q     <= best_d;
`endif
        end
    end

    assign W          = w_q;
    assign J          = j_q;
    assign MinCost    = min_q;
    assign MatchCount = cnt_q;
    assign Valid      = valid_q;

`ifdef JAM_BEST_PERM_EN
    for (genvar i = 0; i < N; i++) begin : g_best
        assign BestPerm[i*IW +: IW] = best_q[i];
    end
`endif

endmodule
